branch_resolve: RTL and testbench

Resolves branches in EX against the prediction made in IF and produces the redirect, flush and predictor-update signals. Prediction bits travel through internal shadow IF/ID and ID/EX registers that follow the pipeline's stall, flush and bubble rules, so every resolution is checked against its own prediction. Drives the redirect mux, the flush inputs of IF/ID and ID/EX, and the update port of the global-history predictor.

---
 rtl/br_pkg.sv | 7 +
 rtl/branch_resolve_if.sv | 40 ++++
 rtl/br_shadow_stage.sv | 59 +++++
 rtl/branch_resolve.sv | 126 ++++++++++++
 tb/tb_branch_resolve.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_pkg.sv
// Shared constants for branch_resolve: shadow-entry field widths, PC step and stats width.
package br_pkg;
  localparam int unsigned SH_VALID_W = 1;
  localparam int unsigned SH_TAKEN_W = 1;
  localparam int unsigned PC_INC     = 4;
  localparam int unsigned STAT_W     = 32;
endpackage

// File: rtl/branch_resolve_if.sv
// Pipeline-facing signal bundle of branch_resolve: IF/EX inputs, stall controls, redirect/update/stats outputs.
interface branch_resolve_if
  import br_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic              if_valid;
  logic [XLEN-1:0]   pc_if;
  logic              pred_taken_if;
  logic [XLEN-1:0]   pred_target_if;
  logic              stall_id;
  logic              stall_ex;
  logic              bubble_ex;
  logic              br_ex;
  logic              taken_ex;
  logic [XLEN-1:0]   target_ex;
  logic              flush_id;
  logic              flush_ex;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_taken;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output if_valid, pc_if, pred_taken_if, pred_target_if,
    output stall_id, stall_ex, bubble_ex, br_ex, taken_ex, target_ex,
    input  flush_id, flush_ex, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, stat_branches, stat_mispred
  );

  modport slave (
    input  if_valid, pc_if, pred_taken_if, pred_target_if,
    input  stall_id, stall_ex, bubble_ex, br_ex, taken_ex, target_ex,
    output flush_id, flush_ex, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, stat_branches, stat_mispred
  );
endinterface

// File: rtl/br_shadow_stage.sv
// One shadow pipeline register carrying {valid, pc, pred_taken, pred_target}; priority clear > hold > load.
module br_shadow_stage
  import br_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  hold,
  input  logic                  load,
  input  logic [SH_VALID_W-1:0] in_valid,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [SH_TAKEN_W-1:0] in_pred_taken,
  input  logic [XLEN-1:0]       in_pred_target,
  output logic [SH_VALID_W-1:0] out_valid,
  output logic [XLEN-1:0]       out_pc,
  output logic [SH_TAKEN_W-1:0] out_pred_taken,
  output logic [XLEN-1:0]       out_pred_target
);
  logic [SH_VALID_W-1:0] valid_q, valid_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [SH_TAKEN_W-1:0] pred_taken_q, pred_taken_d;
  logic [XLEN-1:0]       pred_target_q, pred_target_d;

  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (clr) begin
      valid_d = '0;
    end else if (!hold && load) begin
      valid_d       = in_valid;
      pc_d          = in_pc;
      pred_taken_d  = in_pred_taken;
      pred_target_d = in_pred_target;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q       <= '0;
      pc_q          <= '0;
      pred_taken_q  <= '0;
      pred_target_q <= '0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_pred_taken  = pred_taken_q;
  assign out_pred_target = pred_target_q;
endmodule

// File: rtl/branch_resolve.sv
// Checks each EX branch against its own IF prediction; drives redirect/flush and the predictor update.
// Optional saturating statistics counters are built only when BR_STATS_EN is defined.
module branch_resolve
  import br_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic             clk,
  input logic             rstn,
  branch_resolve_if.slave bus
);
  logic                  id_valid, ex_valid;
  logic [XLEN-1:0]       id_pc, ex_pc;
  logic [SH_TAKEN_W-1:0] id_pred_taken, ex_pred_taken;
  logic [XLEN-1:0]       id_pred_target, ex_pred_target;
  logic                  mispredict;
  logic                  ex_br_taken;
  logic [XLEN-1:0]       redirect_pc;

  br_shadow_stage #(.XLEN(XLEN)) u_ifid (
    .clk             (clk),
    .rstn            (rstn),
    .clr             (mispredict),
    .hold            (bus.stall_id),
    .load            (1'b1),
    .in_valid        (bus.if_valid),
    .in_pc           (bus.pc_if),
    .in_pred_taken   (bus.pred_taken_if),
    .in_pred_target  (bus.pred_target_if),
    .out_valid       (id_valid),
    .out_pc          (id_pc),
    .out_pred_taken  (id_pred_taken),
    .out_pred_target (id_pred_target)
  );

  br_shadow_stage #(.XLEN(XLEN)) u_idex (
    .clk             (clk),
    .rstn            (rstn),
    .clr             (mispredict | bus.bubble_ex),
    .hold            (bus.stall_ex),
    .load            (1'b1),
    .in_valid        (id_valid),
    .in_pc           (id_pc),
    .in_pred_taken   (id_pred_taken),
    .in_pred_target  (id_pred_target),
    .out_valid       (ex_valid),
    .out_pc          (ex_pc),
    .out_pred_taken  (ex_pred_taken),
    .out_pred_target (ex_pred_target)
  );

  // A non-branch resolves as not-taken, which folds the alias case into the direction check.
  always_comb begin
    ex_br_taken = bus.br_ex & bus.taken_ex;
    mispredict  = 1'b0;
    if (ex_valid) begin
      mispredict = (ex_br_taken != ex_pred_taken)
                 | (ex_br_taken & ex_pred_taken & (ex_pred_target != bus.target_ex));
    end
    redirect_pc = ex_br_taken ? bus.target_ex : ex_pc + XLEN'(PC_INC);
  end

  assign bus.flush_id       = mispredict;
  assign bus.flush_ex       = mispredict;
  assign bus.redirect_valid = mispredict;
  assign bus.redirect_pc    = redirect_pc;

  logic            upd_valid_q, upd_valid_d;
  logic [XLEN-1:0] upd_pc_q, upd_pc_d;
  logic            upd_taken_q, upd_taken_d;

  // A held branch reports only on the cycle it actually leaves EX.
  always_comb begin
    upd_valid_d = ex_valid & bus.br_ex & ~bus.stall_ex;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = upd_taken_q;
    if (upd_valid_d) begin
      upd_pc_d    = ex_pc;
      upd_taken_d = bus.taken_ex;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
    end
  end

  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_pc    = upd_pc_q;
  assign bus.upd_taken = upd_taken_q;

`ifdef BR_STATS_EN
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (upd_valid_q && (stat_br_q != '1)) stat_br_d = stat_br_q + STAT_W'(1);
    if (mispredict && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign bus.stat_branches = stat_br_q;
  assign bus.stat_mispred  = stat_mis_q;
`else
  assign bus.stat_branches = '0;
  assign bus.stat_mispred  = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed scenarios followed by random traffic, with an
// abstract two-slot pipeline model pushing expected redirects/updates that a monitor consumes.
module tb_branch_resolve;
  localparam int unsigned XLEN = 32;
  typedef logic [XLEN-1:0] word_t;
  typedef struct packed {logic v; word_t pc; logic pt; word_t ptg;} slot_t;
  typedef struct {int unsigned due; word_t pc; logic tk;} upd_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  branch_resolve_if #(.XLEN(XLEN)) bus();
  branch_resolve #(.XLEN(XLEN)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  word_t       rq[$];
  upd_t        uq[$];
  slot_t       m_id = '0, m_ex = '0, n_id = '0, n_ex = '0;
  logic        m_mis_now = 1'b0, m_leave_now = 1'b0, m_pulse_prev = 1'b0;
  logic [31:0] m_br = '0, m_mis = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs and record what the pipeline should do with them.
  task automatic drive(input logic ifv, input word_t pc, input logic pt, input word_t ptg,
                       input logic sid, input logic sex, input logic bub,
                       input logic br, input logic tk, input word_t tgt);
    logic went, dir_bad, tgt_bad, mis, leave;
    went    = br & tk;
    dir_bad = (went != m_ex.pt);
    tgt_bad = went && m_ex.pt && (tgt != m_ex.ptg);
    mis     = m_ex.v && (dir_bad || tgt_bad);
    if (mis) sex = 1'b0;
    if (mis) rq.push_back(went ? tgt : m_ex.pc + 32'd4);
    leave = m_ex.v && br && !sex;
    if (leave) uq.push_back('{cyc + 1, m_ex.pc, tk});
    n_id = mis ? '0 : (!sid ? slot_t'{ifv, pc, pt, ptg} : m_id);
    n_ex = (mis || bub) ? '0 : (!sex ? m_id : m_ex);
    m_mis_now   = mis;
    m_leave_now = leave;
    bus.if_valid = ifv;  bus.pc_if = pc;  bus.pred_taken_if = pt;  bus.pred_target_if = ptg;
    bus.stall_id = sid;  bus.stall_ex = sex;  bus.bubble_ex = bub;
    bus.br_ex = br;  bus.taken_ex = tk;  bus.target_ex = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    m_id = n_id;
    m_ex = n_ex;
    if (m_mis_now) m_mis++;
    if (m_pulse_prev) m_br++;
    m_pulse_prev = m_leave_now;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic fetch(input word_t pc, input logic pt, input word_t ptg);
    drive(1'b1, pc, pt, ptg, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic ex_cycle(input logic br, input logic tk, input word_t tgt);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, br, tk, tgt);
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    #1;
    chk("rst_redirect_valid", bus.redirect_valid, 0);
    chk("rst_flush_id", bus.flush_id, 0);
    chk("rst_flush_ex", bus.flush_ex, 0);
    chk("rst_upd_valid", bus.upd_valid, 0);
    chk("rst_upd_pc", bus.upd_pc, 0);
    chk("rst_upd_taken", bus.upd_taken, 0);
    chk("rst_stat_branches", bus.stat_branches, 0);
    chk("rst_stat_mispred", bus.stat_mispred, 0);
    rq.delete();
    uq.delete();
    m_id = '0; m_ex = '0; n_id = '0; n_ex = '0;
    m_mis_now = 1'b0; m_leave_now = 1'b0; m_pulse_prev = 1'b0;
    m_br = '0; m_mis = '0;
    tick();
    rstn = 1'b1;
  endtask

  function automatic word_t rand_pc();
    word_t w;
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
    w = $urandom();
    return w & 32'hFFFF_FFFC;
  endfunction

  // Monitor: consumes expectations whenever the DUT is due to present a redirect or update.
  initial begin
    logic  exp_mis, exp_upd;
    word_t exp_pc;
    upd_t  e;
    forever begin
      @(negedge clk);
      exp_mis = (rq.size() != 0);
      chk("redirect_valid", bus.redirect_valid, exp_mis);
      chk("flush_id", bus.flush_id, exp_mis);
      chk("flush_ex", bus.flush_ex, exp_mis);
      if (exp_mis) begin
        exp_pc = rq.pop_front();
        if (bus.redirect_valid) chk("redirect_pc", bus.redirect_pc, exp_pc);
      end
      exp_upd = (uq.size() != 0) && (uq[0].due == cyc);
      chk("upd_valid", bus.upd_valid, exp_upd);
      if (exp_upd) begin
        e = uq.pop_front();
        if (bus.upd_valid) begin
          chk("upd_pc", bus.upd_pc, e.pc);
          chk("upd_taken", bus.upd_taken, e.tk);
        end
      end
`ifdef BR_STATS_EN
      chk("stat_branches", bus.stat_branches, m_br);
      chk("stat_mispred", bus.stat_mispred, m_mis);
`else
      chk("stat_branches", bus.stat_branches, 0);
      chk("stat_mispred", bus.stat_mispred, 0);
`endif
    end
  end

  initial begin
    logic  ifv, pt, sid, sex, bub, br, tk;
    word_t pc, ptg, tgt;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    rstn = 1'b1;

    // Target mispredict: predicted taken to 0x300, resolves taken to 0x310.
    fetch(32'h2F8, 1'b1, 32'h300);
    idle();
    ex_cycle(1'b1, 1'b1, 32'h310);
    #1;
    chk("tgt_redirect_valid", bus.redirect_valid, 1);
    chk("tgt_redirect_pc", bus.redirect_pc, 32'h310);
    tick();
`ifdef BR_STATS_EN
    chk("tgt_stat_mispred", bus.stat_mispred, 1);
`else
    chk("tgt_stat_mispred", bus.stat_mispred, 0);
`endif
    chk("tgt_upd_pc", bus.upd_pc, 32'h2F8);
    idle(); idle();

    // Correct not-taken at 0x100.
    fetch(32'h100, 1'b0, '0);
    idle();
    ex_cycle(1'b1, 1'b0, '0);
    #1;
    chk("nt_flush_id", bus.flush_id, 0);
    chk("nt_redirect_valid", bus.redirect_valid, 0);
    tick();
    chk("nt_upd_valid", bus.upd_valid, 1);
    chk("nt_upd_pc", bus.upd_pc, 32'h100);
    chk("nt_upd_taken", bus.upd_taken, 0);
    idle(); idle();

    // Direction mispredict at 0x200 with younger aliasing instructions behind it.
    fetch(32'h200, 1'b0, '0);
    fetch(32'h204, 1'b1, 32'h900);
    drive(1'b1, 32'h208, 1'b1, 32'h900, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h240);
    #1;
    chk("dir_redirect_valid", bus.redirect_valid, 1);
    chk("dir_flush_id", bus.flush_id, 1);
    chk("dir_flush_ex", bus.flush_ex, 1);
    chk("dir_redirect_pc", bus.redirect_pc, 32'h240);
    tick();
    chk("dir_upd_pc", bus.upd_pc, 32'h200);
    chk("dir_upd_taken", bus.upd_taken, 1);
    for (int unsigned g = 0; g < 2; g++) begin
      ex_cycle(1'b1, 1'b1, 32'h777);
      #1;
      chk("dir_gap_redirect", bus.redirect_valid, 0);
      tick();
      chk("dir_gap_upd", bus.upd_valid, 0);
    end
    idle(); idle();

    // Alias: non-branch predicted taken, including the wrapping PC.
    fetch(32'h400, 1'b1, 32'h480);
    idle();
    ex_cycle(1'b0, 1'b0, '0);
    #1;
    chk("alias_redirect_valid", bus.redirect_valid, 1);
    chk("alias_redirect_pc", bus.redirect_pc, 32'h404);
    tick();
    chk("alias_upd_valid", bus.upd_valid, 0);
    idle(); idle();
    fetch(32'hFFFF_FFFC, 1'b1, 32'h10);
    idle();
    ex_cycle(1'b0, 1'b0, '0);
    #1;
    chk("wrap_redirect_pc", bus.redirect_pc, 32'h0);
    tick();
    idle(); idle();

    // Load-use: branch at 0x500 held in IF/ID while a bubble enters ID/EX.
    fetch(32'h500, 1'b1, 32'h580);
    drive(1'b1, 32'h504, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 32'h504, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    #1;
    chk("lu_bubble_redirect", bus.redirect_valid, 0);
    tick();
    ex_cycle(1'b1, 1'b1, 32'h580);
    #1;
    chk("lu_redirect_valid", bus.redirect_valid, 0);
    tick();
    chk("lu_upd_valid", bus.upd_valid, 1);
    chk("lu_upd_pc", bus.upd_pc, 32'h500);
    ex_cycle(1'b0, 1'b0, '0);
    tick();
    chk("lu_single_upd", bus.upd_valid, 0);
    idle(); idle();

    // Asynchronous reset while a mispredicting branch sits in EX and an update is live.
    fetch(32'h600, 1'b0, '0);
    fetch(32'h604, 1'b0, '0);
    ex_cycle(1'b1, 1'b0, '0);
    tick();
    ex_cycle(1'b1, 1'b1, 32'h700);
    #1;
    chk("pre_rst_redirect_valid", bus.redirect_valid, 1);
    chk("pre_rst_upd_valid", bus.upd_valid, 1);
    async_reset();
    idle();
    chk("post_rst_upd_valid", bus.upd_valid, 0);
    idle(); idle();

    // Random traffic, biased so EX resolutions often agree with their prediction.
    for (int unsigned i = 0; i < 2000; i++) begin
      ifv = ($urandom_range(0, 3) != 0);
      pc  = rand_pc();
      pt  = 1'($urandom_range(0, 1));
      ptg = rand_pc();
      sid = ($urandom_range(0, 5) == 0);
      sex = ($urandom_range(0, 5) == 0);
      bub = ($urandom_range(0, 7) == 0);
      br  = m_ex.pt ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
      tk  = ($urandom_range(0, 3) == 0) ? !m_ex.pt : m_ex.pt;
      tgt = ($urandom_range(0, 3) == 0) ? rand_pc() : m_ex.ptg;
      drive(ifv, pc, pt, ptg, sid, sex, bub, br, tk, tgt);
      if (i == 1000) async_reset();
      else tick();
    end
    for (int unsigned i = 0; i < 4; i++) idle();
    chk("drain_redirect_queue", rq.size(), 0);
    chk("drain_update_queue", uq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
